// File: rtl/addsub_digit_serial.sv
// addsub_digit_serial: multi-cycle two's-complement add/subtract, DIGIT bits per clock, LSD first
module addsub_digit_serial #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             subc,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = N > 1 ? $clog2(N) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] a, b, res, res_n;
   logic [DIGIT:0] dsum;
   logic [CW-1:0] cnt;
   logic carry, am, bm, last;
   always_comb begin
      dsum    = {1'b0, a[DIGIT-1:0]} + {1'b0, b[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
      res_n   = WIDTH'({dsum[DIGIT-1:0], res} >> DIGIT);
      last    = cnt == CW'(N - 1);
      state_n = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
   end
   always_ff @(posedge clk) state <= rst ? IDLE : state_n;
   // am/bm keep the operand sign bits because a/b are shifted away during RUN
   always_ff @(posedge clk) begin
      if (rst) begin
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         a     <= '0;
         b     <= '0;
         res   <= '0;
         cnt   <= '0;
         carry <= 1'b0;
         am    <= 1'b0;
         bm    <= 1'b0;
      end else begin
         busy <= state_n != IDLE;
         done <= state_n == DONE;
         if (state == IDLE && start) begin
            a     <= x;
            b     <= y ^ {WIDTH{subc}};
            carry <= subc;
            cnt   <= '0;
            res   <= '0;
            am    <= x[WIDTH-1];
            bm    <= y[WIDTH-1] ^ subc;
         end else if (state == RUN) begin
            res   <= res_n;
            a     <= a >> DIGIT;
            b     <= b >> DIGIT;
            carry <= dsum[DIGIT];
            cnt   <= cnt + 1'b1;
            if (last) begin
               sum  <= res_n;
               cout <= dsum[DIGIT];
               ovf  <= (am == bm) && (res_n[WIDTH-1] != am);
            end
         end
      end
   end
endmodule
